// File: rtl/dtm_pkg.sv
// Shared encodings for the JTAG debug transport module: IR opcodes, DTMCS layout,
// DMI op/status codes and the DMI transaction FSM states.
package dtm_pkg;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_STAT_OK     = 2'd0,
    DMI_STAT_RSVD   = 2'd1,
    DMI_STAT_FAILED = 2'd2,
    DMI_STAT_BUSY   = 2'd3
  } dmi_stat_e;

  typedef enum logic [1:0] {
    XFER_IDLE,
    XFER_REQ,
    XFER_WAIT
  } xfer_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_DTMCS,
    SEL_DMI
  } dr_sel_e;

  function automatic dr_sel_e decode_ir(logic [4:0] ir);
    case (ir)
      IR_IDCODE: return SEL_IDCODE;
      IR_DTMCS:  return SEL_DTMCS;
      IR_DMI:    return SEL_DMI;
      default:   return SEL_BYPASS;
    endcase
  endfunction

  // {reserved, dmihardreset, dmireset, reserved, idle, dmistat, abits, version}
  function automatic logic [31:0] dtmcs_word(logic [1:0] dmistat, logic [5:0] abits);
    return {14'b0, 2'b00, 1'b0, 3'd1, dmistat, abits, 4'd1};
  endfunction

endpackage

// File: rtl/jtag_dtm_regs_if.sv
// Debug-module interface handshake between the DTM (master) and the debug module (slave).
interface jtag_dtm_regs_if #(
  parameter int ABITS = 7
);
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;
  logic             dmi_rsp_valid;
  logic [31:0]      dmi_rsp_data;
  logic [1:0]       dmi_rsp_op;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );
endinterface

// File: rtl/dmi_xfer.sv
// DMI transaction engine: issues one request at a time, tracks the sticky
// status and latches the response data for the next DMI capture.
module dmi_xfer
  import dtm_pkg::*;
#(
  parameter int ABITS = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tlr_i,
  input  logic             dmireset_i,
  input  logic             hardreset_i,
  input  logic             update_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [31:0]      data_i,
  input  logic [1:0]       op_i,
  output logic [1:0]       status_o,
  output logic [31:0]      rsp_data_o,
  output logic [ABITS-1:0] last_addr_o,
  jtag_dtm_regs_if.master  dmi
);

  xfer_state_e      state_q, state_d;
  dmi_stat_e        sticky_q, sticky_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      rsp_q, rsp_d;

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    sticky_d = sticky_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    rsp_d    = rsp_q;

    case (state_q)
      XFER_IDLE: begin
        if (update_i && sticky_q == DMI_STAT_OK &&
            (op_i == DMI_OP_READ || op_i == DMI_OP_WRITE)) begin
          state_d = XFER_REQ;
          addr_d  = addr_i;
          data_d  = data_i;
          op_d    = op_i;
        end
      end
      XFER_REQ: begin
        if (dmi.dmi_req_ready) state_d = XFER_WAIT;
      end
      XFER_WAIT: begin
        if (dmi.dmi_rsp_valid) begin
          state_d = XFER_IDLE;
          rsp_d   = dmi.dmi_rsp_data;
          if (dmi.dmi_rsp_op == DMI_STAT_FAILED) sticky_d = DMI_STAT_FAILED;
        end
      end
      default: state_d = XFER_IDLE;
    endcase

    // A scan that lands while a transaction is in flight is dropped and flagged.
    if (update_i && state_q != XFER_IDLE) sticky_d = DMI_STAT_BUSY;

    if (dmireset_i) sticky_d = DMI_STAT_OK;
    if (hardreset_i) begin
      sticky_d = DMI_STAT_OK;
      state_d  = XFER_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= XFER_IDLE;
      sticky_q <= DMI_STAT_OK;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      rsp_q    <= '0;
    end else if (tlr_i) begin
      state_q  <= XFER_IDLE;
      sticky_q <= DMI_STAT_OK;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      rsp_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together at the edge.
      state_q  <= state_d;
      sticky_q <= sticky_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      rsp_q    <= rsp_d;
    end
  end

  assign dmi.dmi_req_valid = (state_q == XFER_REQ);
  assign dmi.dmi_req_addr  = addr_q;
  assign dmi.dmi_req_data  = data_q;
  assign dmi.dmi_req_op    = op_q;

  assign status_o    = (state_q != XFER_IDLE) ? DMI_STAT_BUSY : sticky_q;
  assign rsp_data_o  = rsp_q;
  assign last_addr_o = addr_q;

endmodule

// File: rtl/jtag_dtm_regs.sv
// JTAG DTM register file: IR, BYPASS/IDCODE/DTMCS/DMI data registers driven by
// TAP state strobes, with the DMI transaction engine behind the DMI register.
module jtag_dtm_regs
  import dtm_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  parameter int          ABITS  = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tdi,
  input  logic            test_logic_reset,
  input  logic            capture_dr,
  input  logic            shift_dr,
  input  logic            update_dr,
  input  logic            capture_ir,
  input  logic            shift_ir,
  input  logic            update_ir,
  output logic            tdo,
  jtag_dtm_regs_if.master dmi
);

  localparam int DRW = ABITS + 34;

  logic [4:0]       ir_q, ir_d;
  logic [4:0]       ir_sh_q, ir_sh_d;
  logic [DRW-1:0]   dr_sh_q, dr_sh_d;
  dr_sel_e          dr_sel;
  logic [1:0]       dmi_status;
  logic [31:0]      rsp_data;
  logic [ABITS-1:0] last_addr;
  logic             dtmcs_upd;

  assign dr_sel    = decode_ir(ir_q);
  assign dtmcs_upd = update_dr && dr_sel == SEL_DTMCS;

  always_comb begin
    ir_sh_d = ir_sh_q;
    if (capture_ir)    ir_sh_d = 5'b00001;
    else if (shift_ir) ir_sh_d = {tdi, ir_sh_q[4:1]};
    ir_d = update_ir ? ir_sh_q : ir_q;
  end

  // One physical shifter serves every DR; tdi enters at the selected register's MSB.
  always_comb begin
    dr_sh_d = dr_sh_q;
    if (capture_dr) begin
      case (dr_sel)
        SEL_IDCODE: dr_sh_d = DRW'(IDCODE);
        SEL_DTMCS:  dr_sh_d = DRW'(dtmcs_word(dmi_status, 6'(ABITS)));
        SEL_DMI:    dr_sh_d = {last_addr, rsp_data, dmi_status};
        default:    dr_sh_d = '0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_IDCODE, SEL_DTMCS: dr_sh_d = DRW'({tdi, dr_sh_q[31:1]});
        SEL_DMI:               dr_sh_d = {tdi, dr_sh_q[DRW-1:1]};
        default:               dr_sh_d = DRW'(tdi);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= IR_IDCODE;
      ir_sh_q <= '0;
      dr_sh_q <= '0;
    end else if (test_logic_reset) begin
      ir_q    <= IR_IDCODE;
      ir_sh_q <= '0;
      dr_sh_q <= '0;
    end else begin
      ir_q    <= ir_d;
      ir_sh_q <= ir_sh_d;
      dr_sh_q <= dr_sh_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir)      tdo = ir_sh_q[0];
    else if (shift_dr) tdo = dr_sh_q[0];
  end

  dmi_xfer #(.ABITS(ABITS)) u_xfer (
    .clk         (clk),
    .reset       (reset),
    .tlr_i       (test_logic_reset),
    .dmireset_i  (dtmcs_upd && dr_sh_q[DTMCS_DMIRESET_BIT]),
    .hardreset_i (dtmcs_upd && dr_sh_q[DTMCS_HARDRESET_BIT]),
    .update_i    (update_dr && dr_sel == SEL_DMI),
    .addr_i      (dr_sh_q[DRW-1:34]),
    .data_i      (dr_sh_q[33:2]),
    .op_i        (dr_sh_q[1:0]),
    .status_o    (dmi_status),
    .rsp_data_o  (rsp_data),
    .last_addr_o (last_addr),
    .dmi         (dmi)
  );

endmodule

// File: tb/tb_jtag_dtm_regs.sv
// Directed and randomized bench for jtag_dtm_regs against a transaction-level model
// of the DMI status/response rules.
module tb_jtag_dtm_regs;
  import dtm_pkg::*;

  localparam logic [31:0] IDCODE = 32'h0000_0001;
  localparam int          ABITS  = 7;

  logic clk = 1'b0;
  logic reset, tdi, tlr, cdr, sdr, udr, cir, sir, uir;
  logic tdo;

  jtag_dtm_regs_if #(.ABITS(ABITS)) dmi_if ();

  jtag_dtm_regs #(.IDCODE(IDCODE), .ABITS(ABITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .tdi              (tdi),
    .test_logic_reset (tlr),
    .capture_dr       (cdr),
    .shift_dr         (sdr),
    .update_dr        (udr),
    .capture_ir       (cir),
    .shift_ir         (sir),
    .update_ir        (uir),
    .tdo              (tdo),
    .dmi              (dmi_if)
  );

  always #5 clk = ~clk;

  int n_asserts;
  int n_fail;

  // Transaction-level model: is a request being offered, is a response awaited,
  // sticky error, last response word, last issued payload.
  bit          m_req, m_wait;
  logic [1:0]  m_sticky;
  logic [31:0] m_rsp;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_op;

  task automatic model_reset();
    m_req = 0; m_wait = 0; m_sticky = 2'd0; m_rsp = '0;
    m_addr = '0; m_data = '0; m_op = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ir_scan(input logic [4:0] v, output logic [4:0] o);
    o = '0;
    cir = 1; tick(); cir = 0;
    sir = 1;
    for (int i = 0; i < 5; i++) begin
      tdi = v[i]; #1 o[i] = tdo;
      tick();
    end
    sir = 0;
    uir = 1; tick(); uir = 0;
  endtask

  task automatic dr_scan(input logic [63:0] din, input int n, input bit upd, output logic [63:0] dout);
    dout = '0;
    cdr = 1; tick(); cdr = 0;
    sdr = 1;
    for (int i = 0; i < n; i++) begin
      tdi = din[i]; #1 dout[i] = tdo;
      tick();
    end
    sdr = 0;
    if (upd) begin
      udr = 1; tick(); udr = 0;
    end
  endtask

  task automatic check_payload(input string tag);
    check({tag, "_valid"}, 64'(dmi_if.dmi_req_valid), 64'(m_req));
    check({tag, "_addr"},  64'(dmi_if.dmi_req_addr),  64'(m_addr));
    check({tag, "_data"},  64'(dmi_if.dmi_req_data),  64'(m_data));
    check({tag, "_op"},    64'(dmi_if.dmi_req_op),    64'(m_op));
  endtask

  // DMI scan with update; the captured word is compared with the model first.
  task automatic dmi_access(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    logic [63:0] dout;
    logic [1:0]  exp_stat;
    exp_stat = (m_req || m_wait) ? 2'd3 : m_sticky;
    dr_scan({23'b0, a, d, op}, 41, 1'b1, dout);
    check("dmi_cap_status", 64'(dout[1:0]),   64'(exp_stat));
    check("dmi_cap_data",   64'(dout[33:2]),  64'(m_rsp));
    check("dmi_cap_addr",   64'(dout[40:34]), 64'(m_addr));
    if (m_req || m_wait) m_sticky = 2'd3;
    else if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
      m_req = 1; m_addr = a; m_data = d; m_op = op;
    end
    check("dmi_valid_after_update", 64'(dmi_if.dmi_req_valid), 64'(m_req));
  endtask

  task automatic grant();
    dmi_if.dmi_req_ready = 1; tick(); dmi_if.dmi_req_ready = 0;
    if (m_req) begin m_req = 0; m_wait = 1; end
    check("valid_after_grant", 64'(dmi_if.dmi_req_valid), 64'(m_req));
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] op);
    dmi_if.dmi_rsp_valid = 1; dmi_if.dmi_rsp_data = d; dmi_if.dmi_rsp_op = op;
    tick();
    dmi_if.dmi_rsp_valid = 0; dmi_if.dmi_rsp_data = '0; dmi_if.dmi_rsp_op = '0;
    if (m_wait) begin
      m_wait = 0; m_rsp = d;
      if (op == 2'd2) m_sticky = 2'd2;
    end
  endtask

  task automatic dtmcs_scan(input logic [31:0] wr);
    logic [4:0]  ir_o;
    logic [63:0] dout;
    logic [1:0]  exp_stat;
    ir_scan(IR_DTMCS, ir_o);
    exp_stat = (m_req || m_wait) ? 2'd3 : m_sticky;
    dr_scan({32'b0, wr}, 32, 1'b1, dout);
    check("dtmcs_capture", dout, {32'b0, 17'b0, 3'd1, exp_stat, 6'd7, 4'd1});
    if (wr[16] || wr[17]) m_sticky = 2'd0;
    if (wr[17]) begin m_req = 0; m_wait = 0; end
    check("dmi_valid_after_dtmcs", 64'(dmi_if.dmi_req_valid), 64'(m_req));
    ir_scan(IR_DMI, ir_o);
  endtask

  initial begin
    logic [63:0] dout;
    logic [4:0]  ir_o;
    logic [6:0]  a;
    logic [31:0] d;
    logic [1:0]  op;
    int          r;
    bit          busy_hit;

    n_asserts = 0; n_fail = 0;
    model_reset();
    {tdi, tlr, cdr, sdr, udr, cir, sir, uir} = '0;
    dmi_if.dmi_req_ready = 0; dmi_if.dmi_rsp_valid = 0;
    dmi_if.dmi_rsp_data = '0; dmi_if.dmi_rsp_op = '0;

    reset = 0;
    repeat (3) tick();
    check("rst_tdo", 64'(tdo), 64'd0);
    check_payload("rst");
    reset = 1;
    tick();

    dr_scan('0, 32, 1'b0, dout);
    check("idcode_stream", dout, 64'(IDCODE));

    ir_scan(5'h1F, ir_o);
    check("ir_capture_pattern", 64'(ir_o), 64'h01);
    dr_scan(64'b101, 3, 1'b0, dout);
    check("bypass_delay", 64'(dout[2:0]), 64'b010);

    // Write with a stalled ready, then a clean response.
    ir_scan(IR_DMI, ir_o);
    dmi_access(7'h10, 32'hDEADBEEF, 2'd2);
    check_payload("req_issue");
    repeat (3) begin
      tick();
      check_payload("req_stall");
    end
    grant();
    respond(32'h1234_5678, 2'd0);
    dmi_access(7'h01, 32'h0, 2'd0);

    // Busy error, blocked op, dmireset recovery.
    dmi_access(7'h22, 32'hCAFE_0001, 2'd1);
    grant();
    dmi_access(7'h33, 32'hBAD0_0000, 2'd1);
    respond(32'h0000_0F0F, 2'd0);
    dmi_access(7'h44, 32'h0, 2'd1);
    tick();
    check("blocked_op_no_valid", 64'(dmi_if.dmi_req_valid), 64'd0);
    dtmcs_scan(32'h0001_0000);
    dmi_access(7'h55, 32'h0, 2'd1);
    grant();
    respond(32'hA5A5_5A5A, 2'd2);
    dmi_access(7'h00, 32'h0, 2'd0);
    dtmcs_scan(32'h0001_0000);

    // Stray responses outside WAIT are ignored.
    respond(32'hFFFF_FFFF, 2'd2);
    dmi_access(7'h66, 32'h1, 2'd1);
    respond(32'hEEEE_EEEE, 2'd2);
    check_payload("req_after_stray_rsp");

    // dmihardreset drops the request in flight.
    dtmcs_scan(32'h0002_0000);
    dmi_access(7'h00, 32'h0, 2'd0);

    // test_logic_reset mid-flight.
    dmi_access(7'h77, 32'h1357_9BDF, 2'd2);
    grant();
    tlr = 1; tick(); tlr = 0;
    model_reset();
    check_payload("tlr");
    dr_scan('0, 32, 1'b0, dout);
    check("idcode_after_tlr", dout, 64'(IDCODE));

    // Asynchronous reset while a request is offered.
    ir_scan(IR_DMI, ir_o);
    dmi_access(7'h0A, 32'h0BAD_F00D, 2'd1);
    #2 reset = 0;
    #1 model_reset();
    check_payload("async_rst");
    tick();
    reset = 1;
    tick();
    dr_scan('0, 32, 1'b0, dout);
    check("idcode_after_async_rst", dout, 64'(IDCODE));
    ir_scan(IR_DMI, ir_o);

    for (int it = 0; it < 30; it++) begin
      a = 7'($urandom);
      d = $urandom;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
      dmi_access(a, d, op);
      if (m_req) begin
        check_payload("rnd_issue");
        r = $urandom_range(0, 3);
        for (int k = 0; k < r; k++) begin
          if ($urandom_range(0, 2) == 0) respond($urandom, 2'd2);
          else tick();
          check_payload("rnd_stall");
        end
        grant();
        busy_hit = ($urandom_range(0, 4) == 0);
        if (busy_hit) dmi_access(7'($urandom), $urandom, 2'($urandom));
        r = $urandom_range(0, 3);
        repeat (r) tick();
        respond($urandom, busy_hit ? 2'd0 : (($urandom_range(0, 2) == 0) ? 2'd2 : 2'd0));
      end else if ($urandom_range(0, 2) == 0) begin
        respond($urandom, 2'd2);
      end
      if (m_sticky != 2'd0 && $urandom_range(0, 1) == 1)
        dtmcs_scan(($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'h0002_0000);
    end
    dmi_access(7'h00, 32'h0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
